// File: rtl/uart_tx_arbiter_if.sv
// Bundle of client request signals and UART_TOP transmit signals around uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the client/UART side.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_i;
    logic [N_REQ*DATA_WIDTH-1:0] data_i;
    logic [N_REQ-1:0]            par_en_i;
    logic [N_REQ-1:0]            par_typ_i;
    logic [N_REQ-1:0]            grant_o;
    logic [N_REQ-1:0]            ack_o;
    logic                        err_o;
    logic [IDX_W-1:0]            err_src_o;
    logic [DATA_WIDTH-1:0]       tx_p_data;
    logic                        tx_data_valid;
    logic                        tx_par_en;
    logic                        tx_par_typ;
    logic                        tx_busy;

    modport slave (
        input  req_i, data_i, par_en_i, par_typ_i, tx_busy,
        output grant_o, ack_o, err_o, err_src_o,
        output tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
    );

    modport master (
        output req_i, data_i, par_en_i, par_typ_i, tx_busy,
        input  grant_o, ack_o, err_o, err_src_o,
        input  tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TOP transmitter among N_REQ requesters.
// Captures the winner's byte and parity settings, strobes data_valid, and tracks busy until the frame ends.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int BUSY_TO    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      err_src_q, err_src_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  cand_found;
    logic [IDX_W-1:0]      cand_idx;
    logic [IDX_W:0]        scan_sum;
    logic [IDX_W-1:0]      next_ptr;
    logic                  busy_hit;
    logic                  timeout;

    // Scan upward from the pointer with wrap; the extra sum bit absorbs the wrap before folding back.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
            end
            if (!cand_found && bus.req_i[scan_sum[IDX_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
    assign busy_hit = (state_q == WAIT_BUSY) && bus.tx_busy;
    assign timeout  = (state_q == WAIT_BUSY) && !bus.tx_busy && (cnt_q == CNT_W'(BUSY_TO - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        err_src_d = err_src_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (cand_found) begin
                    grant_d   = N_REQ'(1) << cand_idx;
                    win_d     = cand_idx;
                    data_d    = bus.data_i[cand_idx*DATA_WIDTH +: DATA_WIDTH];
                    par_en_d  = bus.par_en_i[cand_idx];
                    par_typ_d = bus.par_typ_i[cand_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_hit) begin
                    state_d = WAIT_DONE;
                end else if (timeout) begin
                    err_src_d = win_q;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (!bus.tx_busy) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            win_q     <= '0;
            ptr_q     <= '0;
            err_src_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            err_src_q <= err_src_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
        end
    end

    // ack and err fire in the WAIT_BUSY cycle that decides the outcome, so err_src is forwarded alongside err.
    assign bus.grant_o       = grant_q;
    assign bus.ack_o         = busy_hit ? grant_q : '0;
    assign bus.err_o         = timeout;
    assign bus.err_src_o     = timeout ? win_q : err_src_q;
    assign bus.tx_data_valid = (state_q == ISSUE);
    assign bus.tx_p_data     = data_q;
    assign bus.tx_par_en     = par_en_q;
    assign bus.tx_par_typ    = par_typ_q;
endmodule
